// File: rtl/spi_sram_dma_engine.sv
// SPI master DMA engine: streams SRAM bytes out over SPI, stores received bytes back,
// or both (full duplex), for a latched address/length on one selectable chip select.
module spi_sram_dma_engine #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8,
    parameter int CS_SEL_WIDTH      = 2,
    parameter int DIV_WIDTH         = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              BGN,
    input  logic                              ABORT,
    input  logic [1:0]                        MODE,
    input  logic [CS_SEL_WIDTH-1:0]           CS_SEL,
    input  logic [MEMORY_ADDR_WIDTH-1:0]      ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0]      DATA_LEN,
    input  logic [DIV_WIDTH-1:0]              FREQ_DIV,
    input  logic [MEMORY_DATA_WIDTH-1:0]      Q,
    input  logic                              SPI_SI,
    output logic                              SCLK,
    output logic [(1<<CS_SEL_WIDTH)-1:0]      CS_N,
    output logic                              SPI_SO,
    output logic                              CEN,
    output logic                              WEN,
    output logic [MEMORY_ADDR_WIDTH-1:0]      A,
    output logic [MEMORY_DATA_WIDTH-1:0]      D,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              ABORTED
);
    localparam int W  = MEMORY_DATA_WIDTH;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [1:0] MODE_WR = 2'b00;
    localparam logic [1:0] MODE_RD = 2'b01;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, STORE, FINISH} state_t;

    state_t                     state, state_next;
    logic [1:0]                 mode_q;
    logic [CS_SEL_WIDTH-1:0]    cs_q;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
    logic [RESERVED_DATA_LEN-1:0] len_q;
    logic [DIV_WIDTH-1:0]       div_q, div_cnt;
    logic [BW-1:0]              bit_cnt;
    logic                       sclk_q;
    logic [W-1:0]               tx_sr, rx_sr;
    logic                       busy_q, done_q, aborted_q;

    logic start, abort_take, advance, tick, last;

    assign tick       = (div_cnt == div_q);
    assign last       = (len_q == RESERVED_DATA_LEN'(1));
    assign abort_take = (state != IDLE) && ABORT;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (BGN) begin
                    start = 1'b1;
                    if (DATA_LEN == '0)        state_next = FINISH;
                    else if (MODE == MODE_RD)  state_next = SHIFT;
                    else                       state_next = FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT:  state_next = SHIFT;
            SHIFT: begin
                // A byte ends on its last falling SCLK edge, leaving SCLK low.
                if (tick && sclk_q && bit_cnt == LAST_BIT) begin
                    if (mode_q == MODE_WR) begin
                        advance    = 1'b1;
                        state_next = last ? FINISH : FETCH;
                    end else begin
                        state_next = STORE;
                    end
                end
            end
            STORE: begin
                advance    = 1'b1;
                if (last)                  state_next = FINISH;
                else if (mode_q == MODE_RD) state_next = SHIFT;
                else                       state_next = FETCH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_take) state_next = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q    <= '0;
            cs_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            div_q     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_q    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else if (abort_take) begin
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
        end else begin
            if (start) begin
                mode_q    <= (MODE == 2'b11) ? MODE_WR : MODE;
                cs_q      <= CS_SEL;
                addr_q    <= ADDR_BGN;
                len_q     <= DATA_LEN;
                div_q     <= FREQ_DIV;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                sclk_q    <= 1'b0;
                tx_sr     <= '0;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            case (state)
                WAIT: begin
                    tx_sr   <= Q;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        sclk_q  <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_sr <= {rx_sr[W-2:0], SPI_SI};
                        end else if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sr   <= {tx_sr[W-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
            if (advance) begin
                addr_q <= addr_q + 1'b1;
                len_q  <= len_q - 1'b1;
            end
        end
    end

    // Chip select stays asserted across the inter-byte FETCH/WAIT/STORE gaps.
    always_comb begin
        CS_N = '1;
        if (state == FETCH || state == WAIT || state == SHIFT || state == STORE)
            CS_N[cs_q] = 1'b0;
    end

    assign SCLK    = sclk_q;
    assign SPI_SO  = (state == SHIFT && mode_q != MODE_RD) ? tx_sr[W-1] : 1'b0;
    assign CEN     = !(state == FETCH || state == STORE);
    assign WEN     = !(state == STORE);
    assign A       = (state == FETCH || state == STORE) ? addr_q : '0;
    assign D       = (state == STORE) ? rx_sr : '0;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ABORTED = aborted_q;

endmodule

// File: doc/spi_sram_dma_engine.md
SPI_SRAM_DMA_ENGINE -- requirements
Module: spi_sram_dma_engine

Interface
REQ-001 SHALL have parameter MEMORY_DATA_WIDTH, default 8: SRAM word width and SPI frame length in bits.
REQ-002 SHALL have parameter MEMORY_ADDR_WIDTH, default 9: SRAM address width.
REQ-003 SHALL have parameter RESERVED_DATA_LEN, default 8: width of the transfer-length field.
REQ-004 SHALL have parameter CS_SEL_WIDTH, default 2: select width; NUM_CS = 2**CS_SEL_WIDTH chip selects.
REQ-005 SHALL have parameter DIV_WIDTH, default 4: clock-divider field width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port list:
- CLK  in  1  rising-edge system clock
- RST  in  1  synchronous active-high reset
- BGN  in  1  start request, sampled only in IDLE
- ABORT  in  1  terminate current transfer
- MODE  in  2  00 write-out, 01 read-in, 10 full-duplex, 11 treated as 00
- CS_SEL  in  CS_SEL_WIDTH  target chip-select index
- ADDR_BGN  in  MEMORY_ADDR_WIDTH  first SRAM address
- DATA_LEN  in  RESERVED_DATA_LEN  byte count
- FREQ_DIV  in  DIV_WIDTH  SCLK half-period minus 1, in CLK cycles
- Q  in  MEMORY_DATA_WIDTH  SRAM read data, valid one cycle after the read cycle
- SPI_SI  in  1  serial input
- SCLK  out  1  serial clock, idle low
- CS_N  out  NUM_CS  active-low chip selects
- SPI_SO  out  1  serial output, MSB first
- CEN  out  1  SRAM enable, active low
- WEN  out  1  SRAM write enable, active low
- A  out  MEMORY_ADDR_WIDTH  SRAM address
- D  out  MEMORY_DATA_WIDTH  SRAM write data
- BUSY  out  1  transfer in progress
- DONE  out  1  level; set at completion, cleared by the next accepted BGN
- ABORTED  out  1  level; set when a transfer ends by ABORT, cleared by the next accepted BGN

Function
REQ-008 The FSM SHALL have states IDLE, FETCH, WAIT, SHIFT, STORE and FINISH.
REQ-009 Only BGN=1 in IDLE SHALL start a transfer: latch MODE, CS_SEL, ADDR_BGN, DATA_LEN and FREQ_DIV; clear DONE and ABORTED; set BUSY the next cycle. BGN while BUSY SHALL be ignored.
REQ-010 DATA_LEN=0 SHALL go IDLE->FINISH with no CS_N assertion and no SRAM access; DONE rises 2 cycles after BGN.
REQ-011 Modes 00 and 10, FETCH: CEN=0, WEN=1, A=current address for exactly 1 cycle.
REQ-012 WAIT: Q SHALL be loaded into the TX shift register at the end of the cycle.
REQ-013 Mode 01 SHALL skip FETCH and WAIT; the TX register is loaded with 0 and SPI_SO is held 0.
REQ-014 SHIFT SHALL drive CS_N[CS_SEL]=0; all other CS_N bits SHALL stay 1.
REQ-015 SHIFT: SCLK toggles every FREQ_DIV+1 CLK cycles, with MEMORY_DATA_WIDTH rising edges per byte; SPI_SO is valid before the first rising edge and changes on falling edges; SPI_SI is sampled on rising edges into the RX register, MSB first.
REQ-016 CS_N SHALL stay low between bytes of one transfer; SCLK SHALL be held low during inter-byte FETCH, WAIT and STORE.
REQ-017 Modes 01 and 10, STORE: CEN=0, WEN=0, A=current address, D=RX byte for exactly 1 cycle. Mode 10 SHALL overwrite the byte just sent.
REQ-018 After each byte the address SHALL increment modulo 2**MEMORY_ADDR_WIDTH (wrap to 0) and the remaining count SHALL decrement.
REQ-019 After the last byte the FSM SHALL enter FINISH: CS_N all 1, DONE=1, BUSY=0 from the next cycle, then return to IDLE.
REQ-020 ABORT=1 while BUSY SHALL take effect the next cycle: CS_N all 1, SCLK=0, CEN=1, WEN=1, no further SRAM write, DONE=1, ABORTED=1, state IDLE. ABORT in IDLE SHALL be ignored.
REQ-021 BGN and ABORT asserted together in IDLE SHALL start the transfer.
REQ-022 Outside FETCH and STORE, CEN=1 and WEN=1.

Reset
REQ-023 RST=1 SHALL, at the next CLK edge and with priority over all inputs, force IDLE, SCLK=0, CS_N all 1, SPI_SO=0, CEN=1, WEN=1, A=0, D=0, BUSY=0, DONE=0 and ABORTED=0.
REQ-024 A reset mid-transfer SHALL discard all latched state, with no SRAM write after the reset edge.

Verification
REQ-025 Mode 00, ADDR_BGN=0x010, DATA_LEN=3, FREQ_DIV=0, SRAM 0xA5,0x3C,0xFF -> SO bitstream A53CFF, 24 SCLK rises, CS_N[CS_SEL] low continuously, DONE=1.
REQ-026 Mode 01, DATA_LEN=2, SI pattern 0x5A,0xC3, FREQ_DIV=3 -> SRAM writes 0x5A@ADDR_BGN and 0xC3@ADDR_BGN+1, SCLK half-period 4 cycles.
REQ-027 Mode 10, ADDR_BGN=0x1FF, DATA_LEN=2 -> reads and writes at 0x1FF then 0x000 (wrap), loopback SI=SO leaves SRAM unchanged.
REQ-028 DATA_LEN=0 -> DONE 2 cycles after BGN, CS_N never low, CEN never low.
REQ-029 ABORT during byte 2 of 4 -> CS_N high next cycle, ABORTED=1, no STORE for byte 2; a BGN during BUSY is ignored.
REQ-030 RST asserted in SHIFT -> all outputs at reset values after 1 edge; a new BGN afterwards runs normally.
